// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_if
// Brief    : Fetch-side lookup and execute-side update bundle of the predictor.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              ce_i;
    logic [ADDR_W-1:0] next_pc_o;
    logic              next_taken_o;
    logic              hit_o;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              upd_uncond_i;

    // The predictor itself.
    modport slave (
        input  pc_i,
        input  ce_i,
        output next_pc_o,
        output next_taken_o,
        output hit_o,
        input  upd_valid_i,
        input  upd_pc_i,
        input  upd_taken_i,
        input  upd_target_i,
        input  upd_uncond_i
    );

    // Fetch and execute units as seen from the predictor's neighbours.
    modport master (
        output pc_i,
        output ce_i,
        input  next_pc_o,
        input  next_taken_o,
        input  hit_o,
        output upd_valid_i,
        output upd_pc_i,
        output upd_taken_i,
        output upd_target_i,
        output upd_uncond_i
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped BTB with 2-bit saturating counters; combinational
//            lookup, registered update.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int BTB_ENTRIES = 16,
    parameter int ADDR_W      = 32
) (
    input  wire                 clk_i,
    input  wire                 rst_i,
    branch_predictor_if.slave   bus
);

    localparam int c_IDX_W = $clog2(BTB_ENTRIES);
    localparam int c_TAG_W = ADDR_W - 2 - c_IDX_W;

    localparam logic [1:0] c_CTR_SNT = 2'b00;
    localparam logic [1:0] c_CTR_WNT = 2'b01;
    localparam logic [1:0] c_CTR_WT  = 2'b10;
    localparam logic [1:0] c_CTR_ST  = 2'b11;

    // ------------------------------------------------------------------
    // Table state
    // ------------------------------------------------------------------
    logic                valid_q  [BTB_ENTRIES];
    logic                valid_d  [BTB_ENTRIES];
    logic [c_TAG_W-1:0]  tag_q    [BTB_ENTRIES];
    logic [c_TAG_W-1:0]  tag_d    [BTB_ENTRIES];
    logic [ADDR_W-1:0]   target_q [BTB_ENTRIES];
    logic [ADDR_W-1:0]   target_d [BTB_ENTRIES];
    logic [1:0]          ctr_q    [BTB_ENTRIES];
    logic [1:0]          ctr_d    [BTB_ENTRIES];

    // ------------------------------------------------------------------
    // Lookup path (pure combinational, reads only registered state)
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0]  w_lk_idx;
    logic [c_TAG_W-1:0]  w_lk_tag;
    logic                w_lk_aligned;
    logic                w_lk_hit;
    logic                w_lk_taken;
    logic [ADDR_W-1:0]   w_seq_pc;

    assign w_lk_idx     = bus.pc_i[c_IDX_W+1:2];
    assign w_lk_tag     = bus.pc_i[ADDR_W-1:c_IDX_W+2];
    assign w_lk_aligned = (bus.pc_i[1:0] == 2'b00);
    assign w_seq_pc     = bus.pc_i + ADDR_W'(4);

    assign w_lk_hit   = bus.ce_i && w_lk_aligned && valid_q[w_lk_idx]
                        && (tag_q[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && ctr_q[w_lk_idx][1];

    assign bus.hit_o        = w_lk_hit;
    assign bus.next_taken_o = w_lk_taken;
    assign bus.next_pc_o    = w_lk_taken ? target_q[w_lk_idx] : w_seq_pc;

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0]  w_up_idx;
    logic [c_TAG_W-1:0]  w_up_tag;
    logic                w_up_accept;
    logic                w_up_hit;
    logic [1:0]          w_up_ctr;
    logic [1:0]          w_ctr_inc;
    logic [1:0]          w_ctr_dec;

    assign w_up_idx    = bus.upd_pc_i[c_IDX_W+1:2];
    assign w_up_tag    = bus.upd_pc_i[ADDR_W-1:c_IDX_W+2];
    assign w_up_accept = bus.upd_valid_i && (bus.upd_pc_i[1:0] == 2'b00);
    assign w_up_hit    = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);
    assign w_up_ctr    = ctr_q[w_up_idx];
    assign w_ctr_inc   = (w_up_ctr == c_CTR_ST)  ? c_CTR_ST  : w_up_ctr + 2'd1;
    assign w_ctr_dec   = (w_up_ctr == c_CTR_SNT) ? c_CTR_SNT : w_up_ctr - 2'd1;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (w_up_accept) begin
            // Unconditional jumps always (re)claim the slot as strongly taken,
            // even if reported with taken low.
            if (bus.upd_uncond_i) begin
                valid_d[w_up_idx]  = 1'b1;
                tag_d[w_up_idx]    = w_up_tag;
                target_d[w_up_idx] = bus.upd_target_i;
                ctr_d[w_up_idx]    = c_CTR_ST;
            end else if (w_up_hit) begin
                if (bus.upd_taken_i) begin
                    ctr_d[w_up_idx]    = w_ctr_inc;
                    target_d[w_up_idx] = bus.upd_target_i;
                end else begin
                    ctr_d[w_up_idx]    = w_ctr_dec;
                end
            end else if (bus.upd_taken_i) begin
                valid_d[w_up_idx]  = 1'b1;
                tag_d[w_up_idx]    = w_up_tag;
                target_d[w_up_idx] = bus.upd_target_i;
                ctr_d[w_up_idx]    = c_CTR_WT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= c_CTR_WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Directed self-checking bench for branch_predictor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.ADDR_W(32)) bus ();

    branch_predictor #(
        .BTB_ENTRIES (16),
        .ADDR_W      (32)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic ce,
                          input logic e_hit, input logic e_taken, input logic [31:0] e_npc);
        bus.pc_i = pc;
        bus.ce_i = ce;
        #1;
        check({tag, ".hit"},   {31'd0, bus.hit_o},        {31'd0, e_hit});
        check({tag, ".taken"}, {31'd0, bus.next_taken_o}, {31'd0, e_taken});
        check({tag, ".npc"},   bus.next_pc_o,             e_npc);
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken,
                       input logic [31:0] target, input logic uncond);
        bus.upd_pc_i     = pc;
        bus.upd_taken_i  = taken;
        bus.upd_target_i = target;
        bus.upd_uncond_i = uncond;
        bus.upd_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.upd_valid_i  = 1'b0;
    endtask

    initial begin
        bus.pc_i         = 32'h0;
        bus.ce_i         = 1'b0;
        bus.upd_valid_i  = 1'b0;
        bus.upd_pc_i     = 32'h0;
        bus.upd_taken_i  = 1'b0;
        bus.upd_target_i = 32'h0;
        bus.upd_uncond_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        lookup("reset", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h8000_0004);

        // Allocation: same-cycle lookup still sees the old contents.
        bus.upd_pc_i     = 32'h8000_0010;
        bus.upd_taken_i  = 1'b1;
        bus.upd_target_i = 32'h8000_0100;
        bus.upd_uncond_i = 1'b0;
        bus.upd_valid_i  = 1'b1;
        lookup("same_cyc", 32'h8000_0010, 1'b1, 1'b0, 1'b0, 32'h8000_0014);
        @(posedge clk);
        #1;
        bus.upd_valid_i = 1'b0;
        lookup("alloc", 32'h8000_0010, 1'b1, 1'b1, 1'b1, 32'h8000_0100);

        // Counter walk: 10 -> 11 (saturate) -> 01 -> 00 (saturate).
        repeat (3) upd(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0);
        lookup("sat_hi", 32'h8000_0010, 1'b1, 1'b1, 1'b1, 32'h8000_0100);
        repeat (2) upd(32'h8000_0010, 1'b0, 32'h0, 1'b0);
        lookup("ctr01", 32'h8000_0010, 1'b1, 1'b1, 1'b0, 32'h8000_0014);
        repeat (3) upd(32'h8000_0010, 1'b0, 32'h0, 1'b0);
        lookup("sat_lo", 32'h8000_0010, 1'b1, 1'b1, 1'b0, 32'h8000_0014);
        upd(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0);
        lookup("no_wrap", 32'h8000_0010, 1'b1, 1'b1, 1'b0, 32'h8000_0014);
        upd(32'h8000_0010, 1'b0, 32'h0, 1'b0);

        // Unconditional jump (reported with taken low) forces counter 11.
        upd(32'h8000_0010, 1'b0, 32'h8000_0300, 1'b1);
        lookup("uncond", 32'h8000_0010, 1'b1, 1'b1, 1'b1, 32'h8000_0300);
        upd(32'h8000_0010, 1'b0, 32'h0, 1'b0);
        lookup("uncond11", 32'h8000_0010, 1'b1, 1'b1, 1'b1, 32'h8000_0300);

        upd(32'h8000_0012, 1'b1, 32'h8000_0400, 1'b1);
        lookup("misalign_upd", 32'h8000_0010, 1'b1, 1'b1, 1'b1, 32'h8000_0300);
        lookup("ce_low", 32'h8000_0010, 1'b0, 1'b0, 1'b0, 32'h8000_0014);
        lookup("misalign_pc", 32'h8000_0012, 1'b1, 1'b0, 1'b0, 32'h8000_0016);

        // Alias onto index 4, update accepted while fetch is disabled.
        bus.ce_i = 1'b0;
        upd(32'h8000_0050, 1'b1, 32'h8000_0200, 1'b0);
        lookup("alias_old", 32'h8000_0010, 1'b1, 1'b0, 1'b0, 32'h8000_0014);
        lookup("alias_new", 32'h8000_0050, 1'b1, 1'b1, 1'b1, 32'h8000_0200);
        upd(32'h8000_0050, 1'b0, 32'h0, 1'b0);
        lookup("alias_ctr10", 32'h8000_0050, 1'b1, 1'b1, 1'b0, 32'h8000_0054);
        upd(32'h8000_0090, 1'b0, 32'h8000_0700, 1'b0);
        lookup("miss_nt_keep", 32'h8000_0050, 1'b1, 1'b1, 1'b0, 32'h8000_0054);
        lookup("miss_nt_none", 32'h8000_0090, 1'b1, 1'b0, 1'b0, 32'h8000_0094);

        lookup("wrap", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0000_0000);

        // Reset wins over a simultaneous taken update.
        rst = 1'b1;
        upd(32'h8000_0020, 1'b1, 32'h8000_0500, 1'b0);
        rst = 1'b0;
        lookup("rst_upd", 32'h8000_0020, 1'b1, 1'b0, 1'b0, 32'h8000_0024);
        lookup("rst_clear", 32'h8000_0050, 1'b1, 1'b0, 1'b0, 32'h8000_0054);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
